fir_mac_seq_ctrl: RTL and testbench

//  Sequencer for the 10-tap FIR MAC datapath. On each input-sample strobe: shifts the 3-bit sample

---
 rtl/fir_mac_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_fir_mac_seq_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_seq_ctrl.sv
// rtl/fir_mac_seq_ctrl.sv - FIR MAC tap sequencer with coefficient SpSram host arbitration
module fir_mac_seq_ctrl #(
  parameter int TAPS     = 10,
  parameter int SAMPLE_W = 3,
  parameter int ADDR_W   = 4
) (
  input  logic                     iClk12M,
  input  logic                     iRsn,
  input  logic                     iEnSample,
  input  logic [SAMPLE_W-1:0]      iFirIn,
  input  logic                     iCoeffUpdateFlag,
  input  logic                     iCsnRam,
  input  logic                     iWrnRam,
  input  logic [ADDR_W-1:0]        iAddrRam,
  input  logic [15:0]              iWrDtRam,
  output logic                     oCsnRam,
  output logic                     oWrnRam,
  output logic [ADDR_W-1:0]        oAddrRam,
  output logic [15:0]              oWrDtRam,
  output logic [TAPS*SAMPLE_W-1:0] oDelay,
  output logic                     oEnMul,
  output logic                     oEnAddAcc,
  output logic                     oMacValid,
  output logic                     oBusy,
  output logic                     oHostGrant,
  output logic                     oOverrun
);

  localparam int DW = TAPS * SAMPLE_W;
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, HOST} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]     delay_q, delay_d;
  logic              csn_q, csn_d;
  logic              en_q, en_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              ovr_q, ovr_d;
  logic              start;
  logic              host_mode;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    csn_d   = csn_q;
    en_d    = 1'b0;
    valid_d = 1'b0;
    ovr_d   = ovr_q;
    start   = 1'b0;

    case (state_q)
      IDLE: begin
        if (iCoeffUpdateFlag) state_d = HOST;
        else if (iEnSample)   start   = 1'b1;
      end
      RUN: begin
        en_d = 1'b1;
        if (iEnSample) ovr_d = 1'b1;
        if (cnt_q == LAST_TAP) begin
          cnt_d   = '0;
          csn_d   = 1'b1;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (iEnSample) ovr_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        // Last cycle of a run doubles as IDLE for acceptance, so strobes may come every 12 cycles
        valid_d = 1'b1;
        state_d = IDLE;
        if (!iCoeffUpdateFlag && iEnSample) start = 1'b1;
      end
      HOST: begin
        if (iEnSample) ovr_d = 1'b1;
        if (!iCoeffUpdateFlag) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = RUN;
      cnt_d   = '0;
      csn_d   = 1'b0;
      delay_d = {delay_q[DW-SAMPLE_W-1:0], iFirIn};
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN) || (state_d == DONE);
  end

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      delay_q <= '0;
      csn_q   <= 1'b1;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      csn_q   <= csn_d;
      en_q    <= en_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  // The tap counter doubles as the read address; it rests at 0 outside a run
  assign host_mode  = (state_q == HOST);
  assign oHostGrant = host_mode;
  assign oCsnRam    = host_mode ? iCsnRam  : csn_q;
  assign oWrnRam    = host_mode ? iWrnRam  : 1'b1;
  assign oAddrRam   = host_mode ? iAddrRam : cnt_q;
  assign oWrDtRam   = host_mode ? iWrDtRam : 16'h0000;
  assign oDelay     = delay_q;
  assign oEnMul     = en_q;
  assign oEnAddAcc  = en_q;
  assign oMacValid  = valid_q;
  assign oBusy      = busy_q;
  assign oOverrun   = ovr_q;

endmodule

// File: tb/tb_fir_mac_seq_ctrl.sv
// tb/tb_fir_mac_seq_ctrl.sv - self-checking bench with SpSram and MAC models plus FIR golden sum
module tb_fir_mac_seq_ctrl;

  logic        iClk12M = 1'b0;
  logic        iRsn;
  logic        iEnSample;
  logic [2:0]  iFirIn;
  logic        iCoeffUpdateFlag;
  logic        iCsnRam;
  logic        iWrnRam;
  logic [3:0]  iAddrRam;
  logic [15:0] iWrDtRam;
  logic        oCsnRam;
  logic        oWrnRam;
  logic [3:0]  oAddrRam;
  logic [15:0] oWrDtRam;
  logic [29:0] oDelay;
  logic        oEnMul;
  logic        oEnAddAcc;
  logic        oMacValid;
  logic        oBusy;
  logic        oHostGrant;
  logic        oOverrun;

  int tests = 0;
  int fails = 0;
  int coef [10];
  int hist [10];
  bit pending;

  logic [15:0] mem [16];
  logic [15:0] ram_rd;
  logic [3:0]  mac_idx;
  int          mac_acc;
  logic [2:0]  mac_slot;

  always #5 iClk12M = ~iClk12M;

  fir_mac_seq_ctrl dut (
    .iClk12M          (iClk12M),
    .iRsn             (iRsn),
    .iEnSample        (iEnSample),
    .iFirIn           (iFirIn),
    .iCoeffUpdateFlag (iCoeffUpdateFlag),
    .iCsnRam          (iCsnRam),
    .iWrnRam          (iWrnRam),
    .iAddrRam         (iAddrRam),
    .iWrDtRam         (iWrDtRam),
    .oCsnRam          (oCsnRam),
    .oWrnRam          (oWrnRam),
    .oAddrRam         (oAddrRam),
    .oWrDtRam         (oWrDtRam),
    .oDelay           (oDelay),
    .oEnMul           (oEnMul),
    .oEnAddAcc        (oEnAddAcc),
    .oMacValid        (oMacValid),
    .oBusy            (oBusy),
    .oHostGrant       (oHostGrant),
    .oOverrun         (oOverrun)
  );

  // External SpSram (read latency 1) and MAC with a wrapping tap index
  assign mac_slot = oDelay[mac_idx*3 +: 3];

  always @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      ram_rd  <= '0;
      mac_idx <= '0;
      mac_acc <= 0;
    end else begin
      if (!oCsnRam) begin
        if (!oWrnRam) mem[oAddrRam] <= oWrDtRam;
        else          ram_rd        <= mem[oAddrRam];
      end
      if (oEnMul) begin
        mac_acc <= (mac_idx == 4'd0 ? 0 : mac_acc) + $signed(ram_rd) * $signed(mac_slot);
        mac_idx <= (mac_idx == 4'd9) ? 4'd0 : mac_idx + 4'd1;
      end
    end
  end

  function automatic logic [29:0] exp_delay();
    logic [29:0] d = '0;
    for (int k = 0; k < 10; k++) d[k*3 +: 3] = hist[k][2:0];
    return d;
  endfunction

  function automatic int golden();
    int s = 0;
    for (int k = 0; k < 10; k++) s += coef[k] * hist[k];
    return s;
  endfunction

  task automatic tick();
    @(posedge iClk12M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_hist(input logic [2:0] s);
    for (int k = 9; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = int'($signed(s));
  endtask

  task automatic idle_pins(input string tag);
    chk({tag, "_csn"},  64'(oCsnRam),  64'(1));
    chk({tag, "_wrn"},  64'(oWrnRam),  64'(1));
    chk({tag, "_addr"}, 64'(oAddrRam), 64'(0));
    chk({tag, "_wdt"},  64'(oWrDtRam), 64'(0));
  endtask

  task automatic reset_outputs(input string tag);
    idle_pins(tag);
    chk({tag, "_delay"}, 64'(oDelay),     64'(0));
    chk({tag, "_en"},    64'(oEnMul),     64'(0));
    chk({tag, "_acc"},   64'(oEnAddAcc),  64'(0));
    chk({tag, "_valid"}, 64'(oMacValid),  64'(0));
    chk({tag, "_busy"},  64'(oBusy),      64'(0));
    chk({tag, "_grant"}, 64'(oHostGrant), 64'(0));
    chk({tag, "_ovr"},   64'(oOverrun),   64'(0));
  endtask

  task automatic do_reset();
    iRsn = 1'b0; iEnSample = 1'b0; iFirIn = 3'd0; iCoeffUpdateFlag = 1'b0;
    iCsnRam = 1'b1; iWrnRam = 1'b1; iAddrRam = 4'd0; iWrDtRam = 16'd0;
    pending = 1'b0;
    for (int k = 0; k < 10; k++) hist[k] = 0;
    repeat (2) tick();
    reset_outputs("rst");
    iRsn = 1'b1;
    tick();
  endtask

  task automatic host_write(input logic [3:0] a, input logic [15:0] w);
    iCsnRam = 1'b0; iWrnRam = 1'b0; iAddrRam = a; iWrDtRam = w;
    #1;
    chk("host_csn",  64'(oCsnRam),  64'(0));
    chk("host_wrn",  64'(oWrnRam),  64'(0));
    chk("host_addr", 64'(oAddrRam), 64'(a));
    chk("host_wdt",  64'(oWrDtRam), 64'(w));
    tick();
    coef[a] = int'($signed(w));
    iCsnRam = 1'b1; iWrnRam = 1'b1;
  endtask

  task automatic host_session(input bit rand_coefs);
    iCoeffUpdateFlag = 1'b1;
    tick();
    chk("hs_grant", 64'(oHostGrant), 64'(1));
    for (int i = 0; i < 10; i++)
      host_write(4'(i), rand_coefs ? 16'($urandom) : 16'(i + 1));
    iCoeffUpdateFlag = 1'b0;
    iWrDtRam = 16'hBEEF;
    tick();
    chk("hs_grant_off", 64'(oHostGrant), 64'(0));
    idle_pins("hs_exit");
    iWrDtRam = 16'd0;
  endtask

  task automatic do_run(input logic [2:0] s, input int strobe_at, input int flag_at,
                        input bit chain, input logic [2:0] next_s);
    int n_en = 0;
    int n_val = 0;
    if (!pending) begin
      iEnSample = 1'b1; iFirIn = s;
      tick();
      iEnSample = 1'b0;
      push_hist(s);
    end
    pending = 1'b0;
    chk("e0_delay", 64'(oDelay),   64'(exp_delay()));
    chk("e0_addr",  64'(oAddrRam), 64'(0));
    chk("e0_csn",   64'(oCsnRam),  64'(0));
    chk("e0_busy",  64'(oBusy),    64'(1));
    for (int e = 1; e <= 12; e++) begin
      if (e == strobe_at) begin iEnSample = 1'b1; iFirIn = ~s; end
      if (e == flag_at) iCoeffUpdateFlag = 1'b1;
      if (e == 12 && chain) begin iEnSample = 1'b1; iFirIn = next_s; end
      tick();
      iEnSample = 1'b0;
      if (oEnMul) n_en++;
      chk("en",    64'(oEnMul),    64'(e <= 10));
      chk("addacc", 64'(oEnAddAcc), 64'(e <= 10));
      if (e <= 9) chk("addr", 64'(oAddrRam), 64'(e));
      chk("csn",   64'(oCsnRam),   64'(e >= 10 && !(e == 12 && chain)));
      chk("busy",  64'(oBusy),     64'(e <= 11 || (e == 12 && chain)));
      chk("valid", 64'(oMacValid), 64'(e == 12));
      if (oMacValid) begin
        n_val++;
        chk("mac", 64'(mac_acc), 64'(golden()));
      end
      if (e == 12 && chain) push_hist(next_s);
      chk("delay", 64'(oDelay), 64'(exp_delay()));
    end
    chk("n_en",    64'(n_en),  64'(10));
    chk("n_valid", 64'(n_val), 64'(1));
    if (chain) pending = 1'b1;
  endtask

  initial begin
    do_reset();

    // Flag and strobe together in IDLE: host wins, sample dropped silently
    iEnSample = 1'b1; iCoeffUpdateFlag = 1'b1; iFirIn = 3'b101;
    tick();
    iEnSample = 1'b0;
    chk("t6_grant", 64'(oHostGrant), 64'(1));
    chk("t6_en",    64'(oEnMul),     64'(0));
    chk("t6_busy",  64'(oBusy),      64'(0));
    chk("t6_ovr",   64'(oOverrun),   64'(0));
    chk("t6_delay", 64'(oDelay),     64'(0));
    tick();
    chk("t6_en2",   64'(oEnMul),     64'(0));
    iCoeffUpdateFlag = 1'b0;
    tick();
    chk("t6_grant_off", 64'(oHostGrant), 64'(0));
    idle_pins("t6_exit");

    host_session(1'b0);
    do_run(3'b011, -1, -1, 1'b0, 3'd0);
    chk("t1_delay", 64'(oDelay), 64'(30'h3));

    do_reset();
    do_run(3'd1, -1, -1, 1'b1, 3'd1);
    do_run(3'd1, -1, -1, 1'b1, 3'd1);
    do_run(3'd1, -1, -1, 1'b0, 3'd0);
    chk("t2_delay", 64'(oDelay),   64'(30'h49));
    chk("t2_ovr",   64'(oOverrun), 64'(0));

    do_run(3'($urandom), 5, -1, 1'b0, 3'd0);
    chk("t3_ovr", 64'(oOverrun), 64'(1));
    tick();
    do_run(3'($urandom), -1, -1, 1'b0, 3'd0);
    chk("t3_ovr_sticky", 64'(oOverrun), 64'(1));

    do_run(3'($urandom), -1, 3, 1'b0, 3'd0);
    chk("t4_grant_idle", 64'(oHostGrant), 64'(0));
    tick();
    chk("t4_grant", 64'(oHostGrant), 64'(1));
    host_write(4'($urandom_range(0, 9)), 16'($urandom));
    iCoeffUpdateFlag = 1'b0;
    tick();
    chk("t4_grant_off", 64'(oHostGrant), 64'(0));
    idle_pins("t4_exit");

    host_session(1'b1);
    for (int i = 0; i < 6; i++) begin
      bit ch;
      ch = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      do_run(3'($urandom), -1, -1, ch, 3'($urandom));
      if (!ch) repeat ($urandom_range(0, 3)) tick();
    end

    // Asynchronous reset in the middle of a run
    iEnSample = 1'b1; iFirIn = 3'($urandom);
    tick();
    iEnSample = 1'b0;
    repeat (6) tick();
    iRsn = 1'b0;
    #1;
    reset_outputs("t5");
    for (int k = 0; k < 10; k++) hist[k] = 0;
    pending = 1'b0;
    #2;
    iRsn = 1'b1;
    tick();
    do_run(3'($urandom), -1, -1, 1'b0, 3'd0);
    chk("t5_ovr", 64'(oOverrun), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
